// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Predicts combinationally at fetch, trains from execute and raises a registered redirect.
module branch_predictor #(
    parameter int N    = 32,
    parameter int IDXW = 6,
    parameter int TAGW = N - IDXW - 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] f_pc,
    output logic         p_taken,
    output logic [N-1:0] p_target,
    input  logic         r_valid,
    input  logic [N-1:0] r_pc,
    input  logic         r_taken,
    input  logic [N-1:0] r_target,
    input  logic         r_pred_taken,
    input  logic [N-1:0] r_pred_target,
    output logic         mispredict,
    output logic [N-1:0] redirect_pc,
    output logic [31:0]  branch_cnt,
    output logic [31:0]  mispred_cnt
);

    localparam int DEPTH = 1 << IDXW;

    logic [DEPTH-1:0] valid_q;
    logic [TAGW-1:0]  tag_q    [DEPTH];
    logic [N-1:0]     target_q [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    logic [IDXW-1:0] f_idx, r_idx;
    logic [TAGW-1:0] f_tag, r_tag;
    logic            f_hit, r_hit;
    logic            mp_cond;
    logic [N-1:0]    redirect_nxt;

    assign f_idx = f_pc[IDXW+1:2];
    assign f_tag = f_pc[N-1:IDXW+2];
    assign r_idx = r_pc[IDXW+1:2];
    assign r_tag = r_pc[N-1:IDXW+2];

    // Lookup reads registered state only, so a same-cycle write shows up next cycle.
    assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign p_taken  = f_hit && ctr_q[f_idx][1];
    assign p_target = f_hit ? target_q[f_idx] : f_pc + N'(4);

    assign r_hit        = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    assign mp_cond      = (r_taken != r_pred_taken) ||
                          (r_taken && r_pred_taken && (r_target != r_pred_target));
    assign redirect_nxt = r_taken ? r_target : r_pc + N'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            mispredict <= r_valid && mp_cond;
            if (r_valid) begin
                if (r_hit) begin
                    ctr_q[r_idx] <= ctr_next(ctr_q[r_idx], r_taken);
                    if (r_taken)
                        target_q[r_idx] <= r_target;
                end else begin
                    // Allocation evicts whatever occupied this index.
                    valid_q[r_idx]  <= 1'b1;
                    tag_q[r_idx]    <= r_tag;
                    target_q[r_idx] <= r_target;
                    ctr_q[r_idx]    <= r_taken ? 2'b10 : 2'b01;
                end
                branch_cnt <= sat_inc(branch_cnt);
                if (mp_cond) begin
                    mispred_cnt <= sat_inc(mispred_cnt);
                    redirect_pc <= redirect_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, saturation, aliasing,
// same-cycle lookup/update, PC wrap and asynchronous reset.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        p_taken;
    logic [31:0] p_target;
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_taken;
    logic [31:0] r_target;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(.N(32), .IDXW(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .f_pc         (f_pc),
        .p_taken      (p_taken),
        .p_target     (p_target),
        .r_valid      (r_valid),
        .r_pc         (r_pc),
        .r_taken      (r_taken),
        .r_target     (r_target),
        .r_pred_taken (r_pred_taken),
        .r_pred_target(r_pred_target),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc),
        .branch_cnt   (branch_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one resolution for a single edge, then sample 2 time units later.
    task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        r_valid       = 1'b1;
        r_pc          = pc;
        r_taken       = tk;
        r_target      = tgt;
        r_pred_taken  = ptk;
        r_pred_target = ptgt;
        @(posedge clk);
        #1;
        r_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        f_pc = 32'h0040_0010;
        r_valid = 1'b0; r_pc = '0; r_taken = 1'b0; r_target = '0;
        r_pred_taken = 1'b0; r_pred_target = '0;

        #12;
        chk("rst_p_taken",  {31'd0, p_taken}, 32'd0);
        chk("rst_p_target", p_target, 32'h0040_0014);
        chk("rst_mispred",  {31'd0, mispredict}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_bcnt",     branch_cnt, 32'd0);
        chk("rst_mcnt",     mispred_cnt, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // First resolution allocates with ctr=10 and mispredicts
        resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014);
        chk("alloc_mispred",  {31'd0, mispredict}, 32'd1);
        chk("alloc_redirect", redirect_pc, 32'h0040_0100);
        chk("alloc_mcnt",     mispred_cnt, 32'd1);
        chk("alloc_bcnt",     branch_cnt, 32'd1);
        chk("alloc_p_taken",  {31'd0, p_taken}, 32'd1);
        chk("alloc_p_target", p_target, 32'h0040_0100);

        // Three correctly predicted taken resolutions saturate at 11
        for (int i = 0; i < 3; i++) begin
            resolve(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
            chk("sat_mispred", {31'd0, mispredict}, 32'd0);
        end
        chk("sat_bcnt", branch_cnt, 32'd4);
        chk("sat_mcnt", mispred_cnt, 32'd1);

        // 11 -> 10: still predicts taken
        resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
        chk("nt1_mispred",  {31'd0, mispredict}, 32'd1);
        chk("nt1_redirect", redirect_pc, 32'h0040_0014);
        chk("nt1_p_taken",  {31'd0, p_taken}, 32'd1);
        chk("nt1_mcnt",     mispred_cnt, 32'd2);

        // 10 -> 01: predicts not-taken, target unchanged
        resolve(32'h0040_0010, 1'b0, 32'h0040_0100, 1'b1, 32'h0040_0100);
        chk("nt2_mispred",  {31'd0, mispredict}, 32'd1);
        chk("nt2_p_taken",  {31'd0, p_taken}, 32'd0);
        chk("nt2_p_target", p_target, 32'h0040_0100);
        chk("nt2_mcnt",     mispred_cnt, 32'd3);
        chk("nt2_bcnt",     branch_cnt, 32'd6);

        @(posedge clk); #2;
        chk("idle_mispred",  {31'd0, mispredict}, 32'd0);
        chk("idle_redirect", redirect_pc, 32'h0040_0014);
        chk("idle_bcnt",     branch_cnt, 32'd6);

        // Aliasing: same index, different tag replaces the entry
        resolve(32'h0040_1010, 1'b0, 32'h0040_1200, 1'b0, 32'h0040_1014);
        chk("alias_mispred", {31'd0, mispredict}, 32'd0);
        chk("alias_old_pt",  {31'd0, p_taken}, 32'd0);
        chk("alias_old_tgt", p_target, 32'h0040_0014);
        f_pc = 32'h0040_1010; #1;
        chk("alias_new_pt",  {31'd0, p_taken}, 32'd0);
        chk("alias_new_tgt", p_target, 32'h0040_1200);
        chk("alias_bcnt",    branch_cnt, 32'd7);
        chk("alias_mcnt",    mispred_cnt, 32'd3);

        // Same-cycle lookup and update of one index
        f_pc = 32'h0040_0020;
        r_valid = 1'b1; r_pc = 32'h0040_0020; r_taken = 1'b1; r_target = 32'h0040_0300;
        r_pred_taken = 1'b0; r_pred_target = 32'h0040_0024;
        #1;
        chk("same_pre_pt",  {31'd0, p_taken}, 32'd0);
        chk("same_pre_tgt", p_target, 32'h0040_0024);
        @(posedge clk); #1; r_valid = 1'b0; #1;
        chk("same_post_pt",  {31'd0, p_taken}, 32'd1);
        chk("same_post_tgt", p_target, 32'h0040_0300);
        chk("same_redirect", redirect_pc, 32'h0040_0300);
        chk("same_mcnt",     mispred_cnt, 32'd4);

        // Fall-through wraps to zero
        resolve(32'hFFFF_FFFC, 1'b0, 32'h0000_1000, 1'b1, 32'h0000_1000);
        chk("wrap_mispred",  {31'd0, mispredict}, 32'd1);
        chk("wrap_redirect", redirect_pc, 32'h0000_0000);
        chk("wrap_bcnt",     branch_cnt, 32'd9);
        chk("wrap_mcnt",     mispred_cnt, 32'd5);

        // Asynchronous reset between edges while a mispredict is in flight
        r_valid = 1'b1; r_pc = 32'h0040_0010; r_taken = 1'b1; r_target = 32'h0040_0500;
        r_pred_taken = 1'b0; r_pred_target = 32'h0040_0014;
        @(posedge clk); #2;
        chk("pre_rst_mispred", {31'd0, mispredict}, 32'd1);
        chk("pre_rst_bcnt",    branch_cnt, 32'd10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_mispred", {31'd0, mispredict}, 32'd0);
        chk("arst_bcnt",    branch_cnt, 32'd0);
        chk("arst_mcnt",    mispred_cnt, 32'd0);
        chk("arst_redir",   redirect_pc, 32'd0);
        chk("arst_pt",      {31'd0, p_taken}, 32'd0);
        chk("arst_ptgt",    p_target, 32'h0040_0024);
        @(posedge clk); #1;
        chk("arst_edge_bcnt", branch_cnt, 32'd0);
        chk("arst_edge_mp",   {31'd0, mispredict}, 32'd0);
        f_pc = 32'h0040_0010; #1;
        chk("arst_edge_pt",   {31'd0, p_taken}, 32'd0);
        chk("arst_edge_tgt",  p_target, 32'h0040_0014);
        r_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_bcnt", branch_cnt, 32'd0);
        chk("post_rst_mp",   {31'd0, mispredict}, 32'd0);
        chk("post_rst_pt",   {31'd0, p_taken}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage consumer of the execute-stage branch condition result.
- Provides a direct-mapped branch target buffer with 2-bit saturating counters that predicts taken/target for each fetch PC.
- Takes the resolved outcome (bcres) and target from execute, trains the table, and raises a registered mispredict/redirect toward fetch and the pipeline flush logic.
- Keeps saturating branch and mispredict statistics.

Parameters:
- N, 32: address/data width.
- IDXW, 6: index width; table holds 2**IDXW entries, indexed by pc[IDXW+1:2].
- TAGW, N-IDXW-2: tag width; tag is pc[N-1:IDXW+2].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- f_pc  in  N  fetch PC for lookup.
- p_taken  out  1  prediction for f_pc: taken; combinational.
- p_target  out  N  predicted target for f_pc; combinational.
- r_valid  in  1  a conditional branch resolves this cycle.
- r_pc  in  N  PC of the resolving branch.
- r_taken  in  1  resolved outcome (bcres from the condition evaluator).
- r_target  in  N  computed branch target.
- r_pred_taken  in  1  prediction originally issued for this branch, piped from fetch.
- r_pred_target  in  N  target originally predicted, piped from fetch.
- mispredict  out  1  registered one-cycle pulse: flush younger stages.
- redirect_pc  out  N  registered correct next PC; valid while mispredict=1.
- branch_cnt  out  32  resolved branches; saturates at 0xFFFFFFFF.
- mispred_cnt  out  32  mispredicts; saturates at 0xFFFFFFFF.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low. On assertion, all entry valid bits=0, all counters=01 (WNT), tags/targets=0, mispredict=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0. Reset mid-resolution discards that resolution entirely.
- Entry contents: valid, tag[TAGW], target[N], ctr[2]. Storage is flops, not RAM.
- Lookup, combinational:
  - hit = valid[idx(f_pc)] and tag matches f_pc.
  - p_taken = hit & ctr[1].
  - p_target = hit ? target : f_pc+4.
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Taken increments and saturates at 11; not-taken decrements and saturates at 00.
- Update on rising clk when r_valid=1:
  - Hit at idx(r_pc): adjust ctr by r_taken. If r_taken, write target=r_target.
  - Miss (invalid entry or tag mismatch): allocate. valid=1, tag=r_pc tag, target=r_target, ctr=10 if r_taken else 01. This replaces any prior occupant.
  - No update when r_valid=0.
- Mispredict:
  - Condition: (r_taken != r_pred_taken) | (r_taken & r_pred_taken & r_target != r_pred_target).
  - Registered: mispredict rises the cycle after r_valid and lasts exactly one cycle unless r_valid is asserted again with another mispredict.
  - redirect_pc = r_taken ? r_target : r_pc+4, computed in mod 2**N arithmetic (wraps at 0xFFFFFFFC+4=0).
  - redirect_pc holds its last value while mispredict=0.
- Statistics: branch_cnt increments on every r_valid; mispred_cnt increments when the mispredict condition is true. Both update in the same edge as the table and neither wraps.
- Same-cycle lookup and update of the same index: the lookup returns the pre-update contents; the write becomes visible the next cycle.
- Alignment: pc[1:0] are ignored for indexing and tag.
- Latency: prediction 0 cycles; table update 1 edge; mispredict 1 cycle after resolution.

Test Plan:
- Reset, then f_pc=0x00400010 -> p_taken=0, p_target=0x00400014; all outputs and counters 0.
- Resolve r_pc=0x00400010, taken, r_target=0x00400100, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x00400100, mispred_cnt=1. Then f_pc=0x00400010 -> p_taken=1, p_target=0x00400100 (ctr=10).
- Same branch resolved taken 3x with correct prediction -> ctr saturates at 11 and mispredict stays 0. Then 1x not-taken (pred 1) -> mispredict, redirect_pc=0x00400014, ctr=10, p_taken still 1. A second not-taken -> ctr=01, p_taken=0.
- Aliasing: r_pc=0x00400010 allocated, then r_pc=0x00401010 (same index, different tag) resolved not-taken -> entry replaced; f_pc=0x00400010 misses with p_taken=0.
- Same-cycle f_pc=r_pc=0x00400020 first-time taken -> p_taken=0 that cycle and 1 the next. Also r_pc=0xFFFFFFFC not-taken with pred 1 -> redirect_pc=0x00000000.
- Assert rst_n=0 asynchronously between edges while r_valid=1 and mispredict=1 -> mispredict, counters and valid bits clear immediately; no update occurs at the following edge.
